multicycle_control_fsm: RTL

//  Multi-cycle control sequencer for the SigmaCore datapath. Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK.

---
 rtl/multicycle_control_fsm_pkg.sv | 69 ++++++
 rtl/multicycle_control_fsm_alu_op_decoder.sv | 67 ++++++
 rtl/multicycle_control_fsm.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the SigmaCore multi-cycle control path: opcodes, FSM states,
// ALU operations and the PC-source / writeback-select mux codes.
package sigma_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] FUNCT7_BASE = 7'h00;
   localparam logic [6:0] FUNCT7_ALT  = 7'h20;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXECUTE,
      MEM,
      WRITEBACK,
      TRAP
   } ctrl_state_e;

   typedef enum logic [3:0] {
      ADD   = 4'd0,
      SUB   = 4'd1,
      SLL   = 4'd2,
      SLT   = 4'd3,
      SLTU  = 4'd4,
      XOR   = 4'd5,
      SRL   = 4'd6,
      SRA   = 4'd7,
      OR    = 4'd8,
      AND   = 4'd9,
      PASSB = 4'd10
   } alu_op_e;

   typedef enum logic [1:0] {
      PC_SRC_SEQ  = 2'd0,
      PC_SRC_REL  = 2'd1,
      PC_SRC_JALR = 2'd2
   } pc_src_e;

   typedef enum logic [1:0] {
      WB_SEL_ALU  = 2'd0,
      WB_SEL_LOAD = 2'd1,
      WB_SEL_PC4  = 2'd2
   } wb_sel_e;

   // funct3 selects the operation class; alt picks SUB over ADD or SRA over SRL.
   function automatic alu_op_e funct_to_alu_op(input logic [2:0] funct3, input logic alt);
      alu_op_e op;
      case (funct3)
         3'b000:  op = alt ? SUB : ADD;
         3'b001:  op = SLL;
         3'b010:  op = SLT;
         3'b011:  op = SLTU;
         3'b100:  op = XOR;
         3'b101:  op = alt ? SRA : SRL;
         3'b110:  op = OR;
         default: op = AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_op_decoder.sv
// Combinational instruction classifier: maps opcode/funct3/funct7 to an ALU
// operation and flags encodings the core does not implement.
module alu_op_decoder
   import sigma_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output alu_op_e    alu_op,
   output logic       illegal
);

   logic funct7_known;

   assign funct7_known = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);

   // NOTE: every output gets a default before the case so no path infers a latch.
   always_comb begin
      alu_op  = ADD;
      illegal = 1'b0;
      case (opcode)
         OPC_OP: begin
            alu_op = funct_to_alu_op(funct3, funct7[5]);
            if (!funct7_known) begin
               illegal = 1'b1;
            end else if ((funct7 == FUNCT7_ALT) && (funct3 != 3'b000) && (funct3 != 3'b101)) begin
               illegal = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            // Only the shift-right immediate borrows funct7; elsewhere those bits are immediate.
            alu_op = funct_to_alu_op(funct3, (funct3 == 3'b101) && funct7[5]);
            if ((funct3 == 3'b001) && (funct7 != FUNCT7_BASE)) begin
               illegal = 1'b1;
            end else if ((funct3 == 3'b101) && !funct7_known) begin
               illegal = 1'b1;
            end
         end
         OPC_LOAD: begin
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         end
         OPC_STORE: begin
            illegal = (funct3 > 3'b010);
         end
         OPC_BRANCH: begin
            alu_op  = SUB;
            illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
         end
         OPC_JAL: begin
            alu_op = ADD;
         end
         OPC_JALR: begin
            illegal = (funct3 != 3'b000);
         end
         OPC_LUI: begin
            alu_op = PASSB;
         end
         OPC_AUIPC: begin
            alu_op = ADD;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// SigmaCore multi-cycle control sequencer: walks each instruction through
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives the datapath strobes.
module multicycle_control_fsm
   import sigma_pkg::*;
#(
   parameter int RETIRE_CNT_W = 32
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              opcode,
   input  logic [2:0]              funct3,
   input  logic [6:0]              funct7,
   input  logic [4:0]              rd,
   input  logic                    imem_valid,
   input  logic                    dmem_ready,
   input  logic                    branch_taken,
   output logic                    imem_req,
   output logic                    ir_load,
   output logic                    dmem_req,
   output logic                    dmem_we,
   output alu_op_e                 alu_op,
   output logic                    pc_write,
   output logic [1:0]              pc_src,
   output logic [1:0]              wb_sel,
   output logic                    reg_write,
   output logic                    trap,
   output logic                    retire,
   output logic [RETIRE_CNT_W-1:0] retire_count
);

   ctrl_state_e             state_q, state_d;
   logic [RETIRE_CNT_W-1:0] retire_count_q, retire_count_d;

   alu_op_e dec_alu_op;
   logic    dec_illegal;
   pc_src_e pc_src_sel;
   wb_sel_e wb_sel_sel;

   logic is_branch, is_load, is_store, is_jal, is_jalr;

   alu_op_decoder u_alu_op_decoder (
      .opcode  (opcode),
      .funct3  (funct3),
      .funct7  (funct7),
      .alu_op  (dec_alu_op),
      .illegal (dec_illegal)
   );

   assign is_branch = (opcode == OPC_BRANCH);
   assign is_load   = (opcode == OPC_LOAD);
   assign is_store  = (opcode == OPC_STORE);
   assign is_jal    = (opcode == OPC_JAL);
   assign is_jalr   = (opcode == OPC_JALR);

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:     if (imem_valid) state_d = DECODE;
         DECODE:    state_d = dec_illegal ? TRAP : EXECUTE;
         EXECUTE: begin
            if (is_branch) begin
               state_d = FETCH;
            end else if (is_load || is_store) begin
               state_d = MEM;
            end else begin
               state_d = WRITEBACK;
            end
         end
         MEM:       if (dmem_ready) state_d = is_store ? FETCH : WRITEBACK;
         WRITEBACK: state_d = FETCH;
         TRAP:      state_d = TRAP;
         default:   state_d = FETCH;
      endcase
   end

   // Strobes decode straight from the registered state so they act in the same cycle.
   always_comb begin
      imem_req   = 1'b0;
      ir_load    = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      alu_op     = ADD;
      pc_write   = 1'b0;
      pc_src_sel = PC_SRC_SEQ;
      wb_sel_sel = WB_SEL_ALU;
      reg_write  = 1'b0;
      trap       = 1'b0;
      retire     = 1'b0;
      case (state_q)
         FETCH: begin
            imem_req = 1'b1;
            ir_load  = imem_valid;
         end
         EXECUTE: begin
            alu_op = dec_alu_op;
            if (is_branch) begin
               pc_write   = 1'b1;
               pc_src_sel = branch_taken ? PC_SRC_REL : PC_SRC_SEQ;
               retire     = 1'b1;
            end
         end
         MEM: begin
            dmem_req = 1'b1;
            dmem_we  = is_store;
            if (dmem_ready && is_store) begin
               pc_write = 1'b1;
               retire   = 1'b1;
            end
         end
         WRITEBACK: begin
            reg_write = (rd != 5'd0);
            pc_write  = 1'b1;
            retire    = 1'b1;
            if (is_jal) begin
               pc_src_sel = PC_SRC_REL;
            end else if (is_jalr) begin
               pc_src_sel = PC_SRC_JALR;
            end
            if (is_load) begin
               wb_sel_sel = WB_SEL_LOAD;
            end else if (is_jal || is_jalr) begin
               wb_sel_sel = WB_SEL_PC4;
            end
         end
         TRAP: begin
            trap = 1'b1;
         end
         default: ;
      endcase
   end

   assign pc_src = pc_src_sel;
   assign wb_sel = wb_sel_sel;

   assign retire_count_d = retire ? retire_count_q + 1'b1 : retire_count_q;

   // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= FETCH;
         retire_count_q <= '0;
      end else begin
         state_q        <= state_d;
         retire_count_q <= retire_count_d;
      end
   end

   assign retire_count = retire_count_q;

endmodule
